// File: rtl/arbitro_reg_rr_pkg.sv
// Shared state encoding and default sizing for the round-robin register arbiter.
// Imported by the interface, the flip-flop bank and the arbiter top.
package arbitro_reg_rr_pkg;

  // 2'b11 is unused and drops back to OCIOSO if it ever appears.
  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    CARGA    = 2'b01,
    CONFIRMA = 2'b10
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_IDX_W = 2;

endpackage

// File: rtl/arbitro_reg_rr_if.sv
// Requester-side bundle: level requests and data in; grant, ack, owner and stored value out.
// The master modport is the requester view, the slave modport is the arbiter view.
interface arbitro_reg_rr_if
  import arbitro_reg_rr_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W
) ();

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic                   ack;
  logic [IDX_W-1:0]       owner;
  logic                   busy;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       qn;

  modport master (
    output req, wdata,
    input  gnt, ack, owner, busy, q, qn
  );

  modport slave (
    input  req, wdata,
    output gnt, ack, owner, busy, q, qn
  );

endinterface

// File: rtl/arbitro_reg_rr_registrador_ffd.sv
// WIDTH-bit D flip-flop bank with load enable and synchronous clear; q visible one edge after en.
// No flow control: holds its value whenever en is low, clr wins over en.
module registrador_ffd
  import arbitro_reg_rr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

  assign qn = ~q;

endmodule

// File: rtl/arbitro_reg_rr.sv
// Round-robin arbiter and load sequencer for one shared register: grant after E0, load+ack after E1, release after E2.
// One transfer per 3 cycles; losing requesters just keep req high and are served in rotating order.
module arbitro_reg_rr
  import arbitro_reg_rr_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input logic             clk,
  input logic             clr,
  arbitro_reg_rr_if.slave bus
);

  localparam logic [IDX_W:0]   N_REQ_X  = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             ack_q, ack_d;
  logic             ld_en;

  logic [N_REQ-1:0] req_rot;
  logic             win_vld;
  logic [IDX_W:0]   win_sum;
  logic [IDX_W-1:0] win_idx;
  logic [WIDTH-1:0] wsel;
  logic [WIDTH-1:0] q_int;
  logic [WIDTH-1:0] qn_int;

  // Rotate the request vector so bit 0 is the requester at ptr; the lowest set bit is the winner's offset.
  assign req_rot = N_REQ'({bus.req, bus.req} >> ptr_q);

  always_comb begin
    win_vld = 1'b0;
    win_sum = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_vld = 1'b1;
        win_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      end
    end
    win_idx = (win_sum >= N_REQ_X) ? IDX_W'(win_sum - N_REQ_X) : win_sum[IDX_W-1:0];
  end

  always_comb begin
    wsel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner_q == IDX_W'(k)) begin
        wsel = bus.wdata[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    ack_d   = 1'b0;
    ld_en   = 1'b0;
    case (state_q)
      OCIOSO: begin
        gnt_d = '0;
        if (win_vld) begin
          gnt_d   = N_REQ'(1) << win_idx;
          owner_d = win_idx;
          state_d = CARGA;
        end
      end
      CARGA: begin
        ld_en   = 1'b1;
        ack_d   = 1'b1;
        state_d = CONFIRMA;
      end
      CONFIRMA: begin
        gnt_d   = '0;
        ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
        state_d = OCIOSO;
      end
      default: begin
        gnt_d   = '0;
        state_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= OCIOSO;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
    end
  end

  registrador_ffd #(
    .WIDTH(WIDTH)
  ) u_reg (
    .clk(clk),
    .clr(clr),
    .en (ld_en),
    .d  (wsel),
    .q  (q_int),
    .qn (qn_int)
  );

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q != OCIOSO);
  assign bus.q     = q_int;
  assign bus.qn    = qn_int;

endmodule

// File: tb/tb_arbitro_reg_rr.sv
// Bench for arbitro_reg_rr: directed scenarios with hand-derived constants, then random traffic against a transfer-level model.
module tb_arbitro_reg_rr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic clr;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  arbitro_reg_rr_if #(.N_REQ(N), .WIDTH(W), .IDX_W(IW)) bus ();

  arbitro_reg_rr #(.N_REQ(N), .WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Transfer-level model: m_phase counts edges since the grant (0 = no transfer in flight).
  int         m_phase = 0;
  int         m_ptr   = 0;
  int         m_owner = 0;
  logic [W-1:0] m_q   = '0;

  task automatic mdl_step();
    int i;
    if (clr) begin
      m_phase = 0;
      m_ptr   = 0;
      m_owner = 0;
      m_q     = '0;
    end else if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (bus.req[i]) begin
          m_owner = i;
          m_phase = 1;
          break;
        end
      end
    end else if (m_phase == 1) begin
      m_q     = bus.wdata[m_owner*W +: W];
      m_phase = 2;
    end else begin
      m_ptr   = (m_owner + 1) % N;
      m_phase = 0;
    end
  endtask

  function automatic logic [23:0] mdl_exp();
    logic [3:0] g;
    g = (m_phase != 0) ? 4'(1 << m_owner) : 4'b0000;
    return {g, (m_phase == 2), (m_phase != 0), IW'(m_owner), m_q, ~m_q};
  endfunction

  // Observed outputs packed as {gnt, ack, busy, owner, q, qn}.
  function automatic logic [23:0] obs();
    return {bus.gnt, bus.ack, bus.busy, bus.owner, bus.q, bus.qn};
  endfunction

  task automatic tick();
    @(posedge clk);
    mdl_step();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    logic [23:0] act, exp;
    clr = 1'b1;
    bus.req = 4'b1111;
    bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    tick();
    act = obs(); exp = {4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 8'hFF};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", act, exp); end
    clr = 1'b0;
    tick();
    act = obs(); exp = {4'b0001, 1'b0, 1'b1, 2'd0, 8'h00, 8'hFF};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL reset_first_grant got=%h exp=%h", act, exp); end
    bus.req = 4'b0000;
    tick();
    act = obs(); exp = {4'b0001, 1'b1, 1'b1, 2'd0, 8'h11, 8'hEE};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL reset_first_load got=%h exp=%h", act, exp); end
    tick();
    act = obs(); exp = {4'b0000, 1'b0, 1'b0, 2'd0, 8'h11, 8'hEE};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL reset_first_release got=%h exp=%h", act, exp); end
  endtask

  task automatic test_single_write();
    logic [23:0] act, exp;
    bus.req = 4'b0100;
    bus.wdata[2*W +: W] = 8'hA5;
    tick();
    act = obs(); exp = {4'b0100, 1'b0, 1'b1, 2'd2, 8'h11, 8'hEE};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL single_grant got=%h exp=%h", act, exp); end
    tick();
    act = obs(); exp = {4'b0100, 1'b1, 1'b1, 2'd2, 8'hA5, 8'h5A};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL single_load got=%h exp=%h", act, exp); end
    bus.req = 4'b0000;
    tick();
    act = obs(); exp = {4'b0000, 1'b0, 1'b0, 2'd2, 8'hA5, 8'h5A};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL single_release got=%h exp=%h", act, exp); end
  endtask

  task automatic test_skip_wrap();
    logic [23:0] act, exp;
    bus.req = 4'b1001;
    bus.wdata[3*W +: W] = 8'h99;
    bus.wdata[0*W +: W] = 8'h90;
    tick();
    act = obs(); exp = {4'b1000, 1'b0, 1'b1, 2'd3, 8'hA5, 8'h5A};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL wrap_grant3 got=%h exp=%h", act, exp); end
    tick();
    act = obs(); exp = {4'b1000, 1'b1, 1'b1, 2'd3, 8'h99, 8'h66};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL wrap_load3 got=%h exp=%h", act, exp); end
    tick();
    act = obs(); exp = {4'b0000, 1'b0, 1'b0, 2'd3, 8'h99, 8'h66};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL wrap_release3 got=%h exp=%h", act, exp); end
    tick();
    act = obs(); exp = {4'b0001, 1'b0, 1'b1, 2'd0, 8'h99, 8'h66};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL wrap_grant0 got=%h exp=%h", act, exp); end
    tick();
    act = obs(); exp = {4'b0001, 1'b1, 1'b1, 2'd0, 8'h90, 8'h6F};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL wrap_load0 got=%h exp=%h", act, exp); end
    bus.req = 4'b0011;
    tick();
    tick();
    act = obs(); exp = {4'b0010, 1'b0, 1'b1, 2'd1, 8'h90, 8'h6F};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL wrap_ptr_at_1 got=%h exp=%h", act, exp); end
    bus.req = 4'b0000;
    tick();
    act = obs(); exp = {4'b0010, 1'b1, 1'b1, 2'd1, 8'h22, 8'hDD};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL wrap_load1 got=%h exp=%h", act, exp); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [23:0] act, exp;
    logic [7:0]  rr_d [4];
    logic [7:0]  prevq;
    logic [3:0]  eg;
    int          last_ack;
    int          i;
    rr_d[0] = 8'hA0; rr_d[1] = 8'hB1; rr_d[2] = 8'hC2; rr_d[3] = 8'hD3;
    clr = 1'b1;
    bus.req = 4'b0000;
    tick();
    clr = 1'b0;
    bus.wdata = {rr_d[3], rr_d[2], rr_d[1], rr_d[0]};
    bus.req = 4'b1111;
    prevq = 8'h00;
    last_ack = -1;
    for (int k = 0; k < 5; k++) begin
      i = k % N;
      eg = 4'(1 << i);
      tick();
      act = obs(); exp = {eg, 1'b0, 1'b1, IW'(i), prevq, ~prevq};
      n_tests++;
      if (act !== exp) begin n_fail++; $display("FAIL rr_grant_%0d got=%h exp=%h", k, act, exp); end
      tick();
      prevq = rr_d[i];
      act = obs(); exp = {eg, 1'b1, 1'b1, IW'(i), prevq, ~prevq};
      n_tests++;
      if (act !== exp) begin n_fail++; $display("FAIL rr_load_%0d got=%h exp=%h", k, act, exp); end
      if (last_ack >= 0) begin
        n_tests++;
        if (cyc - last_ack !== 3) begin
          n_fail++; $display("FAIL rr_ack_spacing_%0d got=%0d exp=3", k, cyc - last_ack);
        end
      end
      last_ack = cyc;
      if (k == 4) bus.req = 4'b0000;
      tick();
      act = obs(); exp = {4'b0000, 1'b0, 1'b0, IW'(i), prevq, ~prevq};
      n_tests++;
      if (act !== exp) begin n_fail++; $display("FAIL rr_release_%0d got=%h exp=%h", k, act, exp); end
    end
  endtask

  task automatic test_early_drop();
    logic [23:0] act, exp;
    bus.req = 4'b0010;
    bus.wdata[1*W +: W] = 8'h3C;
    bus.wdata[3*W +: W] = 8'h77;
    tick();
    act = obs(); exp = {4'b0010, 1'b0, 1'b1, 2'd1, 8'hA0, 8'h5F};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL drop_grant got=%h exp=%h", act, exp); end
    bus.req = 4'b0000;
    tick();
    act = obs(); exp = {4'b0010, 1'b1, 1'b1, 2'd1, 8'h3C, 8'hC3};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL drop_still_loads got=%h exp=%h", act, exp); end
    bus.req = 4'b1000;
    tick();
    act = obs(); exp = {4'b0000, 1'b0, 1'b0, 2'd1, 8'h3C, 8'hC3};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL drop_confirm_ignores_req got=%h exp=%h", act, exp); end
    tick();
    act = obs(); exp = {4'b1000, 1'b0, 1'b1, 2'd3, 8'h3C, 8'hC3};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL drop_next_grant got=%h exp=%h", act, exp); end
    bus.req = 4'b0000;
    tick();
    act = obs(); exp = {4'b1000, 1'b1, 1'b1, 2'd3, 8'h77, 8'h88};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL drop_next_load got=%h exp=%h", act, exp); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [23:0] act, exp;
    bus.req = 4'b0001;
    bus.wdata[0*W +: W] = 8'h11;
    tick();
    act = obs(); exp = {4'b0001, 1'b0, 1'b1, 2'd0, 8'h77, 8'h88};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL mid_grant got=%h exp=%h", act, exp); end
    clr = 1'b1;
    bus.req = 4'b0000;
    tick();
    act = obs(); exp = {4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 8'hFF};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL mid_abort got=%h exp=%h", act, exp); end
    clr = 1'b0;
    tick();
    act = obs(); exp = {4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 8'hFF};
    n_tests++;
    if (act !== exp) begin n_fail++; $display("FAIL mid_idle got=%h exp=%h", act, exp); end
  endtask

  task automatic test_random();
    logic [23:0] act, exp;
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 39) == 0);
      bus.req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      bus.wdata = $urandom;
      tick();
      act = obs(); exp = mdl_exp();
      n_tests++;
      if (act !== exp) begin n_fail++; $display("FAIL random_cycle_%0d got=%h exp=%h", c, act, exp); end
    end
  endtask

  initial begin
    clr = 1'b1;
    bus.req = '0;
    bus.wdata = '0;
    test_reset();
    test_single_write();
    test_skip_wrap();
    test_round_robin();
    test_early_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
